digitally_controlled_oscillator: RTL and testbench

//  Counter-based DCO for the ADPLL: generates the clock that the phase detector compares against the reference.

---
 rtl/adpll_pkg.sv | 23 ++
 rtl/half_period_counter.sv | 35 +++
 rtl/digitally_controlled_oscillator.sv | 100 ++++++++++
 tb/tb_digitally_controlled_oscillator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared ADPLL constants and the saturating clamp used by the DCO
// and the loop filter.
package adpll_pkg;

  localparam int FPGA_CLK_HZ  = 400_000_000;
  localparam int REF_CLK_HZ   = 5_000_000;
  localparam int NOMINAL_HALF = FPGA_CLK_HZ / REF_CLK_HZ / 2;
  localparam int MIN_HALF     = 4;
  localparam int MAX_HALF     = 4095;
  localparam int PD_WIDTH     = 20;
  localparam int CLAMP_W      = 32;

  function automatic logic signed [CLAMP_W-1:0] clamp_signed(
    input logic signed [CLAMP_W-1:0] value,
    input logic signed [CLAMP_W-1:0] lo,
    input logic signed [CLAMP_W-1:0] hi
  );
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/half_period_counter.sv
// Down-counter that measures one half period of the generated clock and
// flags the terminal count so the top level can toggle the output.
module half_period_counter #(
  parameter int HP_W      = 16,
  parameter int RESET_CNT = 39
) (
  input  logic            fpga_clk_i,
  input  logic            reset_i,
  input  logic            enable_i,
  input  logic [HP_W-1:0] reload_i,
  output logic            tick_o
);
  import adpll_pkg::*;

  logic [HP_W-1:0] cnt_q;
  logic [HP_W-1:0] cnt_d;

  assign tick_o = enable_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (enable_i) begin
      cnt_d = (cnt_q == '0) ? reload_i : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      cnt_q <= HP_W'(RESET_CNT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/digitally_controlled_oscillator.sv
// Counter-based DCO: toggles generated_o every half period and folds one
// handshaked phase correction into the half period at each rising edge.
module digitally_controlled_oscillator #(
  parameter int WIDTH        = adpll_pkg::PD_WIDTH,
  parameter int HP_W         = 16,
  parameter int NOMINAL_HALF = adpll_pkg::NOMINAL_HALF,
  parameter int MIN_HALF     = adpll_pkg::MIN_HALF,
  parameter int MAX_HALF     = adpll_pkg::MAX_HALF,
  parameter int GAIN_SHIFT   = 0
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic signed [WIDTH-1:0] correction_i,
  input  logic                    correction_valid_i,
  output logic                    correction_ready_o,
  output logic                    generated_o,
  output logic                    rising_edge_o,
  output logic [HP_W-1:0]         half_period_o
);
  import adpll_pkg::*;

  localparam int EW = ((HP_W > WIDTH) ? HP_W : WIDTH) + 2;

  logic                    gen_q, gen_d;
  logic                    rise_q, rise_d;
  logic                    pending_q, pending_d;
  logic                    ready_q, ready_d;
  logic [HP_W-1:0]         half_q, half_d;
  logic signed [WIDTH-1:0] corr_q, corr_d;
  logic signed [WIDTH-1:0] corr_scaled;
  logic signed [EW-1:0]    half_sum;
  logic [HP_W-1:0]         reload;
  logic                    tick;
  logic                    rise_toggle;
  logic                    apply;
  logic                    accept;

  half_period_counter #(
    .HP_W      (HP_W),
    .RESET_CNT (NOMINAL_HALF - 1)
  ) u_counter (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .reload_i   (reload),
    .tick_o     (tick)
  );

  // A correction accepted on the same edge as a rising toggle is not yet
  // pending, so it waits for the following rising edge.
  always_comb begin
    corr_scaled = corr_q >>> GAIN_SHIFT;
    half_sum    = $signed({{(EW-HP_W){1'b0}}, half_q})
                + $signed({{(EW-WIDTH){corr_scaled[WIDTH-1]}}, corr_scaled});
    rise_toggle = tick && !gen_q;
    apply       = rise_toggle && pending_q;
    accept      = correction_valid_i && ready_q;
    gen_d       = tick ? !gen_q : gen_q;
    rise_d      = rise_toggle;
    half_d      = half_q;
    if (apply) begin
      half_d = HP_W'(clamp_signed($signed({{(CLAMP_W-EW){half_sum[EW-1]}}, half_sum}),
                                  MIN_HALF, MAX_HALF));
    end
    pending_d = pending_q;
    if (apply) begin
      pending_d = 1'b0;
    end else if (accept) begin
      pending_d = 1'b1;
    end
    ready_d = !pending_d;
    corr_d  = accept ? correction_i : corr_q;
    reload  = half_d - 1'b1;
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      gen_q     <= 1'b0;
      rise_q    <= 1'b0;
      half_q    <= HP_W'(NOMINAL_HALF);
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      corr_q    <= '0;
    end else begin
      gen_q     <= gen_d;
      rise_q    <= rise_d;
      half_q    <= half_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      corr_q    <= corr_d;
    end
  end

  assign generated_o        = gen_q;
  assign rising_edge_o      = rise_q;
  assign half_period_o      = half_q;
  assign correction_ready_o = ready_q;

endmodule

// File: tb/tb_digitally_controlled_oscillator.sv
// Self-checking bench for the DCO: a cycle-level behavioural model compared
// every cycle, plus directed scenarios with hand-computed edge timings.
module tb_digitally_controlled_oscillator;

  localparam int WIDTH = 20;
  localparam int HP_W  = 16;

  logic                    fpga_clk_i = 1'b0;
  logic                    reset_i = 1'b1;
  logic                    enable_i = 1'b0;
  logic signed [WIDTH-1:0] correction_i = '0;
  logic                    correction_valid_i = 1'b0;
  logic                    correction_ready_o;
  logic                    generated_o;
  logic                    rising_edge_o;
  logic [HP_W-1:0]         half_period_o;

  int checks = 0;
  int failures = 0;

  always #5 fpga_clk_i = ~fpga_clk_i;

  digitally_controlled_oscillator #(
    .WIDTH        (WIDTH),
    .HP_W         (HP_W),
    .NOMINAL_HALF (40),
    .MIN_HALF     (4),
    .MAX_HALF     (4095),
    .GAIN_SHIFT   (0)
  ) dut (
    .fpga_clk_i         (fpga_clk_i),
    .reset_i            (reset_i),
    .enable_i           (enable_i),
    .correction_i       (correction_i),
    .correction_valid_i (correction_valid_i),
    .correction_ready_o (correction_ready_o),
    .generated_o        (generated_o),
    .rising_edge_o      (rising_edge_o),
    .half_period_o      (half_period_o)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int clampHalf(input int v);
    if (v < 4) return 4;
    if (v > 4095) return 4095;
    return v;
  endfunction

  // Model: count enabled edges since the last toggle; when the count reaches
  // the half period in force, toggle, and on a rise consume a queued correction.
  bit m_valid = 1'b0;
  bit m_gen, m_rise, m_ready;
  int m_half, m_elapsed;
  int m_pend[$];

  always @(posedge fpga_clk_i) begin : model_step
    bit acc;
    acc = correction_valid_i && m_ready;
    if (reset_i) begin
      m_valid   = 1'b1;
      m_gen     = 1'b0;
      m_rise    = 1'b0;
      m_half    = 40;
      m_elapsed = 0;
      m_pend.delete();
    end else begin
      m_rise = 1'b0;
      if (enable_i) begin
        m_elapsed++;
        if (m_elapsed == m_half) begin
          m_elapsed = 0;
          m_gen = !m_gen;
          if (m_gen) begin
            m_rise = 1'b1;
            if (m_pend.size() > 0) begin
              m_half = clampHalf(m_half + (m_pend[0] >>> 0));
              m_pend.pop_front();
            end
          end
        end
      end
      if (acc) m_pend.push_back(int'(correction_i));
    end
    m_ready = (m_pend.size() == 0);
  end

  always @(negedge fpga_clk_i) begin
    if (m_valid) begin
      checkOutput("model_gen", int'(generated_o), int'(m_gen));
      checkOutput("model_rise", int'(rising_edge_o), int'(m_rise));
      checkOutput("model_half", int'(half_period_o), m_half);
      checkOutput("model_ready", int'(correction_ready_o), int'(m_ready));
    end
  end

  int obs_gen[0:255];
  int obs_rise[0:255];
  int obs_half[0:255];
  int obs_ready[0:255];
  int held_acc;
  int last_n;

  task automatic applyStimulus(input bit rst, input bit en, input bit vld, input int corr);
    @(negedge fpga_clk_i);
    reset_i            = rst;
    enable_i           = en;
    correction_valid_i = vld;
    correction_i       = corr[WIDTH-1:0];
    @(posedge fpga_clk_i);
    #2;
  endtask

  function automatic int toggleCycle(input int k);
    int found;
    found = 0;
    for (int c = 1; c <= last_n; c++) begin
      if (obs_gen[c] != obs_gen[c-1]) begin
        found++;
        if (found == k) return c;
      end
    end
    return -1;
  endfunction

  task automatic runScenario(input int s, input int n);
    bit rst, en, vld, held_done;
    int corr;
    held_done = 1'b0;
    held_acc  = -1;
    last_n    = n;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    obs_gen[0]   = int'(generated_o);
    obs_rise[0]  = int'(rising_edge_o);
    obs_half[0]  = int'(half_period_o);
    obs_ready[0] = int'(correction_ready_o);
    for (int c = 1; c <= n; c++) begin
      rst = 1'b0; en = 1'b1; vld = 1'b0; corr = 0;
      case (s)
        2: if (c == 50) begin vld = 1'b1; corr = 10; end
        3: if (c == 50) begin vld = 1'b1; corr = -100; end
           else if (c >= 60 && !held_done) begin vld = 1'b1; corr = 20000; end
        4: if (c == 50) begin vld = 1'b1; corr = 5; end
           else if (c >= 60 && !held_done) begin vld = 1'b1; corr = -3; end
        5: begin
             en = !(c >= 20 && c <= 39);
             if (c == 25) begin vld = 1'b1; corr = 6; end
           end
        6: begin
             rst = (c == 100);
             if (c == 50) begin vld = 1'b1; corr = 7; end
           end
        7: if (c == 40) begin vld = 1'b1; corr = 10; end
        default: ;
      endcase
      applyStimulus(rst, en, vld, corr);
      if ((s == 3 || s == 4) && c >= 60 && vld && !held_done && obs_ready[c-1] == 1) begin
        held_done = 1'b1;
        held_acc  = c;
      end
      obs_gen[c]   = int'(generated_o);
      obs_rise[c]  = int'(rising_edge_o);
      obs_half[c]  = int'(half_period_o);
      obs_ready[c] = int'(correction_ready_o);
    end
  endtask

  initial begin
    int rises;

    runScenario(1, 205);
    checkOutput("s1_reset_half", obs_half[0], 40);
    checkOutput("s1_reset_gen", obs_gen[0], 0);
    checkOutput("s1_reset_ready", obs_ready[0], 1);
    checkOutput("s1_tog1", toggleCycle(1), 40);
    checkOutput("s1_tog2", toggleCycle(2), 80);
    checkOutput("s1_tog3", toggleCycle(3), 120);
    checkOutput("s1_tog4", toggleCycle(4), 160);
    checkOutput("s1_tog5", toggleCycle(5), 200);
    rises = 0;
    for (int c = 1; c <= 205; c++) rises += obs_rise[c];
    checkOutput("s1_rise_count", rises, 3);
    checkOutput("s1_rise40", obs_rise[40], 1);
    checkOutput("s1_rise41", obs_rise[41], 0);
    checkOutput("s1_rise120", obs_rise[120], 1);
    checkOutput("s1_rise200", obs_rise[200], 1);
    checkOutput("s1_half_end", obs_half[205], 40);

    runScenario(2, 225);
    checkOutput("s2_ready49", obs_ready[49], 1);
    checkOutput("s2_ready50", obs_ready[50], 0);
    checkOutput("s2_ready119", obs_ready[119], 0);
    checkOutput("s2_ready120", obs_ready[120], 1);
    checkOutput("s2_half119", obs_half[119], 40);
    checkOutput("s2_half120", obs_half[120], 50);
    checkOutput("s2_fall", toggleCycle(4), 170);
    checkOutput("s2_rise", toggleCycle(5), 220);

    runScenario(3, 135);
    checkOutput("s3_half_min", obs_half[120], 4);
    checkOutput("s3_accept", held_acc, 121);
    checkOutput("s3_fall", toggleCycle(4), 124);
    checkOutput("s3_half127", obs_half[127], 4);
    checkOutput("s3_half_max", obs_half[128], 4095);

    runScenario(4, 215);
    checkOutput("s4_half120", obs_half[120], 45);
    checkOutput("s4_ready120", obs_ready[120], 1);
    checkOutput("s4_accept", held_acc, 121);
    checkOutput("s4_ready121", obs_ready[121], 0);
    checkOutput("s4_fall", toggleCycle(4), 165);
    checkOutput("s4_rise", toggleCycle(5), 210);
    checkOutput("s4_half209", obs_half[209], 45);
    checkOutput("s4_half210", obs_half[210], 42);

    runScenario(5, 70);
    checkOutput("s5_gen39", obs_gen[39], 0);
    checkOutput("s5_ready25", obs_ready[25], 0);
    checkOutput("s5_first_rise", toggleCycle(1), 60);
    checkOutput("s5_rise_pulse", obs_rise[60], 1);
    checkOutput("s5_half60", obs_half[60], 46);

    runScenario(6, 150);
    checkOutput("s6_pending99", obs_ready[99], 0);
    checkOutput("s6_gen100", obs_gen[100], 0);
    checkOutput("s6_half100", obs_half[100], 40);
    checkOutput("s6_ready100", obs_ready[100], 1);
    checkOutput("s6_rise_after", toggleCycle(3), 140);
    checkOutput("s6_half140", obs_half[140], 40);

    runScenario(7, 125);
    checkOutput("s7_rise40", obs_rise[40], 1);
    checkOutput("s7_half40", obs_half[40], 40);
    checkOutput("s7_ready40", obs_ready[40], 0);
    checkOutput("s7_tog3", toggleCycle(3), 120);
    checkOutput("s7_half120", obs_half[120], 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
